// File: rtl/multicycle_ctrl.sv
// Multicycle CPU sequencer: FETCH/DECODE/EXEC/MEM/WB control with
// memory-wait timeouts, PC update at commit and performance counters.
module multicycle_ctrl #(
  parameter logic [31:0] RESET_PC = 32'h1C000000,
  parameter int          WAIT_W   = 4,
  parameter int          MAX_WAIT = 15,
  parameter int          CNT_W    = 32
) (
  input  logic             cpu_clk,
  input  logic             rst,
  input  logic             run,
  input  logic             step,
  input  logic [2:0]       op_class,
  input  logic             br_taken,
  input  logic [31:0]      br_target,
  input  logic             imem_ack,
  input  logic             dmem_ack,
  output logic [31:0]      pc,
  output logic             imem_req,
  output logic             ir_we,
  output logic             ab_we,
  output logic             y_we,
  output logic             dmem_req,
  output logic             dmem_we,
  output logic             mdr_we,
  output logic             rf_we,
  output logic             wb_sel,
  output logic [2:0]       state,
  output logic             halted,
  output logic [1:0]       err,
  output logic [CNT_W-1:0] cycle_cnt,
  output logic [CNT_W-1:0] instr_cnt
);

  typedef enum logic [2:0] {
    S_IDLE, S_FETCH, S_DECODE, S_EXEC, S_MEM, S_WB, S_HALT, S_BAD
  } state_t;

  localparam logic [1:0] OP_ALU = 2'd0, OP_LOAD = 2'd1, OP_STORE = 2'd2, OP_BRANCH = 2'd3;
  localparam logic [1:0] E_NONE = 2'd0, E_ILL = 2'd1, E_IMEM = 2'd2, E_DMEM = 2'd3;
  localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(MAX_WAIT - 1);

  state_t            state_q, state_d;
  logic [31:0]       pc_q, pc_d, next_pc;
  logic [1:0]        op_q, op_d;
  logic [1:0]        err_q, err_d;
  logic [WAIT_W-1:0] wait_q, wait_d;
  logic [CNT_W-1:0]  cyc_q, cyc_d, ins_q, ins_d;
  logic              commit;

  always_ff @(posedge cpu_clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      pc_q    <= RESET_PC;
      op_q    <= OP_ALU;
      err_q   <= E_NONE;
      wait_q  <= '0;
      cyc_q   <= '0;
      ins_q   <= '0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      op_q    <= op_d;
      err_q   <= err_d;
      wait_q  <= wait_d;
      cyc_q   <= cyc_d;
      ins_q   <= ins_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    pc_d     = pc_q;
    op_d     = op_q;
    err_d    = err_q;
    wait_d   = '0;
    cyc_d    = cyc_q;
    ins_d    = ins_q;
    next_pc  = pc_q + 32'd4;
    commit   = 1'b0;
    imem_req = 1'b0;
    ir_we    = 1'b0;
    ab_we    = 1'b0;
    y_we     = 1'b0;
    dmem_req = 1'b0;
    dmem_we  = 1'b0;
    mdr_we   = 1'b0;
    rf_we    = 1'b0;
    wb_sel   = 1'b0;

    if (state_q != S_IDLE && state_q != S_HALT) cyc_d = cyc_q + CNT_W'(1);

    case (state_q)
      S_IDLE: if (run || step) state_d = S_FETCH;
      S_FETCH: begin
        imem_req = 1'b1;
        if (imem_ack) begin
          ir_we   = 1'b1;
          state_d = S_DECODE;
        end else if (wait_q == WAIT_LAST) begin
          state_d = S_HALT;
          err_d   = E_IMEM;
        end else begin
          wait_d = wait_q + WAIT_W'(1);
        end
      end
      S_DECODE: begin
        ab_we = 1'b1;
        op_d  = op_class[1:0];
        if (op_class[2]) begin
          state_d = S_HALT;
          err_d   = E_ILL;
        end else begin
          state_d = S_EXEC;
        end
      end
      S_EXEC: begin
        // Branch condition and target are consumed here, so no holding copy is needed.
        y_we = 1'b1;
        case (op_q)
          OP_ALU:  state_d = S_WB;
          OP_LOAD, OP_STORE: state_d = S_MEM;
          default: begin
            if (br_taken && br_target[1:0] != 2'b00) begin
              state_d = S_HALT;
              err_d   = E_ILL;
            end else begin
              commit = 1'b1;
              if (br_taken) next_pc = br_target;
            end
          end
        endcase
      end
      S_MEM: begin
        dmem_req = 1'b1;
        dmem_we  = (op_q == OP_STORE);
        if (dmem_ack) begin
          if (op_q == OP_LOAD) begin
            mdr_we  = 1'b1;
            state_d = S_WB;
          end else begin
            commit = 1'b1;
          end
        end else if (wait_q == WAIT_LAST) begin
          state_d = S_HALT;
          err_d   = E_DMEM;
        end else begin
          wait_d = wait_q + WAIT_W'(1);
        end
      end
      S_WB: begin
        rf_we  = 1'b1;
        wb_sel = (op_q == OP_LOAD);
        commit = 1'b1;
      end
      S_HALT: ;
      default: begin
        state_d = S_HALT;
        err_d   = E_ILL;
      end
    endcase

    if (commit) begin
      pc_d    = next_pc;
      ins_d   = ins_q + CNT_W'(1);
      state_d = run ? S_FETCH : S_IDLE;
    end
  end

  assign pc        = pc_q;
  assign state     = state_q;
  assign halted    = (state_q == S_HALT);
  assign err       = err_q;
  assign cycle_cnt = cyc_q;
  assign instr_cnt = ins_q;

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Bench for multicycle_ctrl: instructions are expanded into an expected
// per-cycle trace (inputs to drive plus outputs to see), replayed and checked.
module tb_multicycle_ctrl;
  localparam int          MAXW = 15;
  localparam logic [31:0] RPC  = 32'h1C000000;
  localparam bit [2:0] IDLE = 3'd0, FETCH = 3'd1, DEC = 3'd2, EXE = 3'd3, MEM = 3'd4, WB = 3'd5, HALT = 3'd6;
  localparam int B_IREQ = 9, B_IRWE = 8, B_ABWE = 7, B_YWE = 6, B_DREQ = 5,
                 B_DWE = 4, B_MDR = 3, B_RFWE = 2, B_WBSEL = 1, B_HALT = 0;

  logic cpu_clk = 1'b0, rst = 1'b1, run = 1'b0, step = 1'b0;
  logic [2:0] op_class = 3'd0;
  logic br_taken = 1'b0;
  logic [31:0] br_target = 32'd0;
  logic imem_ack = 1'b0, dmem_ack = 1'b0;
  logic [31:0] pc;
  logic imem_req, ir_we, ab_we, y_we, dmem_req, dmem_we, mdr_we, rf_we, wb_sel, halted;
  logic [2:0] state;
  logic [1:0] err;
  logic [31:0] cycle_cnt, instr_cnt;

  multicycle_ctrl dut (
    .cpu_clk(cpu_clk), .rst(rst), .run(run), .step(step), .op_class(op_class),
    .br_taken(br_taken), .br_target(br_target), .imem_ack(imem_ack), .dmem_ack(dmem_ack),
    .pc(pc), .imem_req(imem_req), .ir_we(ir_we), .ab_we(ab_we), .y_we(y_we),
    .dmem_req(dmem_req), .dmem_we(dmem_we), .mdr_we(mdr_we), .rf_we(rf_we), .wb_sel(wb_sel),
    .state(state), .halted(halted), .err(err), .cycle_cnt(cycle_cnt), .instr_cnt(instr_cnt)
  );

  always #5 cpu_clk = ~cpu_clk;

  typedef struct {
    bit rst, run, step, bt, iack, dack;
    bit [2:0] op;
    bit [31:0] tgt;
    bit [2:0] st;
    bit [31:0] pc;
    bit [9:0] sig;
    bit [1:0] err;
    bit [31:0] cyc, ins;
  } rec_t;

  rec_t trace[$];
  int n_total = 0, n_bad = 0;

  // Architectural model state
  bit [31:0] mpc = RPC, mcyc = 0, minstr = 0;
  bit [1:0]  merr = 0;
  bit c_run = 0, c_step = 0, c_bt = 0, c_stray = 0;
  bit [2:0] c_op = 0;
  bit [31:0] c_tgt = 0;

  function automatic rec_t mk(input bit [2:0] st);
    rec_t r;
    r.rst = 0; r.run = c_run; r.step = c_step; r.op = c_op; r.bt = c_bt; r.tgt = c_tgt;
    r.iack = c_stray; r.dack = c_stray;
    r.st = st; r.pc = mpc; r.sig = '0; r.err = merr; r.cyc = mcyc; r.ins = minstr;
    if (st != IDLE && st != HALT) mcyc++;
    return r;
  endfunction

  function automatic void add_reset();
    rec_t r;
    c_run = 0; c_step = 0;
    mpc = RPC; mcyc = 0; minstr = 0; merr = 0;
    r = mk(IDLE); r.rst = 1;
    trace.push_back(r);
  endfunction

  function automatic void add_idle(input bit rn, input bit sp);
    rec_t r;
    c_run = rn; c_step = sp;
    r = mk(IDLE);
    trace.push_back(r);
    c_step = 0;
  endfunction

  function automatic void add_halt(input int n);
    rec_t r;
    c_run = 1; c_step = 1;
    for (int k = 0; k < n; k++) begin
      r = mk(HALT); r.sig[B_HALT] = 1;
      trace.push_back(r);
    end
    c_step = 0;
  endfunction

  // One instruction: idly/ddly = cycles before the ack (>= MAXW means never),
  // rst_at = index of the cycle replaced by a reset pulse (-1 for none).
  function automatic void add_instr(input bit [2:0] op, input int idly, input int ddly,
                                    input bit taken, input bit [31:0] tgt,
                                    input bit rn, input int rst_at);
    rec_t q[$];
    rec_t r;
    bit dead = 0;
    c_run = rn; c_op = op; c_bt = taken; c_tgt = tgt;
    for (int d = 0; d < MAXW; d++) begin
      r = mk(FETCH); r.iack = (d == idly); r.sig[B_IREQ] = 1; r.sig[B_IRWE] = (d == idly);
      q.push_back(r);
      if (d == idly) break;
    end
    if (idly >= MAXW) begin merr = 2; dead = 1; end
    if (!dead) begin
      r = mk(DEC); r.sig[B_ABWE] = 1; q.push_back(r);
      if (op > 3) begin merr = 1; dead = 1; end
    end
    if (!dead) begin
      r = mk(EXE); r.sig[B_YWE] = 1; q.push_back(r);
      if (op == 3 && taken && tgt[1:0] != 0) begin merr = 1; dead = 1; end
    end
    if (!dead && (op == 1 || op == 2)) begin
      for (int d = 0; d < MAXW; d++) begin
        r = mk(MEM); r.dack = (d == ddly);
        r.sig[B_DREQ] = 1; r.sig[B_DWE] = (op == 2); r.sig[B_MDR] = (op == 1 && d == ddly);
        q.push_back(r);
        if (d == ddly) break;
      end
      if (ddly >= MAXW) begin merr = 3; dead = 1; end
    end
    if (!dead && (op == 0 || op == 1)) begin
      r = mk(WB); r.sig[B_RFWE] = 1; r.sig[B_WBSEL] = (op == 1); q.push_back(r);
    end
    if (!dead) begin
      mpc = (op == 3 && taken) ? tgt : mpc + 32'd4;
      minstr++;
    end
    if (rst_at >= 0 && rst_at < q.size()) begin
      for (int k = 0; k < rst_at; k++) trace.push_back(q[k]);
      add_reset();
    end else begin
      foreach (q[k]) trace.push_back(q[k]);
    end
  endfunction

  task automatic chk_lit(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s got=%h want=%h", name, act, exp);
    end
  endtask

  initial begin
    int n0;
    logic [110:0] act_v, exp_v;

    add_reset(); add_reset();
    add_idle(0, 0);
    // Back-to-back ALU with acks tied high, then run dropped during the 4th
    c_stray = 1;
    add_idle(1, 0);
    add_instr(0, 0, 0, 0, 0, 1, -1);
    add_instr(0, 0, 0, 0, 0, 1, -1);
    add_instr(0, 0, 0, 0, 0, 1, -1);
    chk_lit("model_alu3_pc", mpc, 32'h1C00000C);
    add_instr(0, 0, 0, 0, 0, 0, -1);
    add_idle(0, 0);
    c_stray = 0;
    // Single-stepped LOAD with a 3-cycle dmem wait
    add_idle(0, 1);
    n0 = trace.size();
    add_instr(1, 0, 3, 0, 0, 0, -1);
    chk_lit("model_load_len", trace.size() - n0, 8);
    chk_lit("model_load_instr", minstr, 5);
    add_idle(0, 0);
    // run+step together, taken and untaken branch, STORE, ALU with ack on the last allowed cycle
    add_idle(1, 1);
    n0 = trace.size();
    add_instr(3, 0, 0, 1, 32'h1C000100, 1, -1);
    chk_lit("model_branch_len", trace.size() - n0, 3);
    chk_lit("model_branch_pc", mpc, 32'h1C000100);
    add_instr(3, 1, 0, 0, 32'h1C000200, 1, -1);
    add_instr(2, 2, 0, 0, 0, 1, -1);
    n0 = trace.size();
    add_instr(0, 14, 0, 0, 0, 0, -1);
    chk_lit("model_ackwin_len", trace.size() - n0, 18);
    add_idle(0, 0);
    // Misaligned taken branch
    add_idle(0, 1);
    add_instr(3, 0, 0, 1, 32'h1C000102, 0, -1);
    add_halt(3);
    add_reset(); add_idle(0, 0);
    // Illegal op class
    add_idle(1, 0);
    add_instr(5, 0, 0, 0, 0, 1, -1);
    add_halt(2);
    add_reset(); add_idle(0, 0);
    // imem timeout
    add_idle(1, 0);
    n0 = trace.size();
    add_instr(0, 99, 0, 0, 0, 1, -1);
    chk_lit("model_imem_to_len", trace.size() - n0, 15);
    add_halt(2);
    add_reset(); add_idle(0, 0);
    // dmem timeout on LOAD
    add_idle(1, 0);
    add_instr(1, 1, 99, 0, 0, 1, -1);
    add_halt(2);
    add_reset(); add_idle(0, 0);
    // Reset during MEM of a STORE
    add_idle(1, 0);
    add_instr(0, 0, 0, 0, 0, 1, -1);
    add_instr(2, 0, 5, 0, 0, 1, 4);
    add_idle(0, 0); add_idle(0, 0);

    foreach (trace[i]) begin
      @(posedge cpu_clk); #1;
      rst = trace[i].rst; run = trace[i].run; step = trace[i].step;
      op_class = trace[i].op; br_taken = trace[i].bt; br_target = trace[i].tgt;
      imem_ack = trace[i].iack; dmem_ack = trace[i].dack;
      @(negedge cpu_clk);
      act_v = {state, pc, imem_req, ir_we, ab_we, y_we, dmem_req, dmem_we, mdr_we,
               rf_we, wb_sel, halted, err, cycle_cnt, instr_cnt};
      exp_v = {trace[i].st, trace[i].pc, trace[i].sig, trace[i].err, trace[i].cyc, trace[i].ins};
      n_total++;
      if (act_v !== exp_v) begin
        n_bad++;
        $display("FAIL cycle%0d st/pc/sig/err/cyc/ins got=%h/%h/%b/%0d/%0d/%0d want=%h/%h/%b/%0d/%0d/%0d",
                 i, state, pc, act_v[77:68], err, cycle_cnt, instr_cnt,
                 trace[i].st, trace[i].pc, trace[i].sig, trace[i].err, trace[i].cyc, trace[i].ins);
      end
    end
    chk_lit("end_pc", pc, 32'h1C000000);
    chk_lit("end_instr", instr_cnt, 0);
    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end
endmodule
